// File: rtl/if_prefetch_stage_pkg.sv
// Shared opcode/funct encodings, instruction-type codes and width constants
// for the fetch stage and the later pipeline stages that reuse the decoder.
package if_prefetch_stage_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned TYPE_W    = 4;
  localparam int unsigned MIN_DEPTH = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_SLL = 6'h00;
  localparam logic [5:0] FUNC_SRL = 6'h02;
  localparam logic [5:0] FUNC_SRA = 6'h03;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_NOR = 6'h27;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  typedef enum logic [TYPE_W-1:0] {
    INST_TYPE_NONE = 4'd0,
    INST_TYPE_ADD  = 4'd1,
    INST_TYPE_SUB  = 4'd2,
    INST_TYPE_AND  = 4'd3,
    INST_TYPE_OR   = 4'd4,
    INST_TYPE_NOR  = 4'd5,
    INST_TYPE_SLT  = 4'd6,
    INST_TYPE_SLL  = 4'd7,
    INST_TYPE_SRL  = 4'd8,
    INST_TYPE_SRA  = 4'd9,
    INST_TYPE_LW   = 4'd10,
    INST_TYPE_SW   = 4'd11,
    INST_TYPE_BEQ  = 4'd12,
    INST_TYPE_BNE  = 4'd13,
    INST_TYPE_JMP  = 4'd14
  } inst_type_e;

endpackage

// File: rtl/if_prefetch_stage_inst_type_decoder.sv
// Purely combinational instruction classifier: 32-bit instruction word to
// 4-bit type code; unknown encodings map to INST_TYPE_NONE.
module inst_type_decoder
  import if_prefetch_stage_pkg::*;
(
  input  logic [INST_W-1:0] i_inst,
  output logic [TYPE_W-1:0] o_type
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused_bits;

  assign w_op          = i_inst[31:26];
  assign w_funct       = i_inst[5:0];
  // Register/immediate fields do not influence the type.
  assign w_unused_bits = ^i_inst[25:6];

  always_comb begin
    o_type = INST_TYPE_NONE;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FUNC_ADD: o_type = INST_TYPE_ADD;
          FUNC_SUB: o_type = INST_TYPE_SUB;
          FUNC_AND: o_type = INST_TYPE_AND;
          FUNC_OR:  o_type = INST_TYPE_OR;
          FUNC_NOR: o_type = INST_TYPE_NOR;
          FUNC_SLT: o_type = INST_TYPE_SLT;
          FUNC_SLL: o_type = INST_TYPE_SLL;
          FUNC_SRL: o_type = INST_TYPE_SRL;
          FUNC_SRA: o_type = INST_TYPE_SRA;
          default:  o_type = INST_TYPE_NONE;
        endcase
      end
      OP_ADDI: o_type = INST_TYPE_ADD;
      OP_ANDI: o_type = INST_TYPE_AND;
      OP_ORI:  o_type = INST_TYPE_OR;
      OP_LW:   o_type = INST_TYPE_LW;
      OP_SW:   o_type = INST_TYPE_SW;
      OP_BEQ:  o_type = INST_TYPE_BEQ;
      OP_BNE:  o_type = INST_TYPE_BNE;
      OP_JMP:  o_type = INST_TYPE_JMP;
      default: o_type = INST_TYPE_NONE;
    endcase
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a circular prefetch queue between the
// synchronous instruction memory and ID; redirect/reset flush the queue.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       IMEM_AW  = 8,
  parameter int unsigned       PC_STEP  = 1,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         imem_rd,
  output logic [IMEM_AW-1:0]           imem_addr,
  input  logic [INST_W-1:0]            imem_dout,
  output logic                         if_valid,
  output logic [ADDR_W-1:0]            if_pc,
  output logic [ADDR_W-1:0]            if_pc4,
  output logic [INST_W-1:0]            if_inst,
  output logic [TYPE_W-1:0]            ID_ins_type,
  output logic [3:0]                   ID_ins_number,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned       PTR_W   = $clog2((DEPTH < MIN_DEPTH) ? MIN_DEPTH : DEPTH);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] r_fpc;
  logic              r_pend;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [INST_W-1:0] r_q_inst [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];

  logic [CNT_W:0]    w_occ;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [TYPE_W-1:0] w_dec_type;

  // A read in flight reserves its slot; a same-cycle pop is deliberately not credited.
  assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pend};
  assign w_issue = !rst && !redirect && (w_occ < DEPTH_C);
  assign w_push  = r_pend && !redirect && !rst;
  assign w_pop   = if_valid && !stall && !redirect;

  assign imem_rd   = w_issue;
  assign imem_addr = r_fpc[IMEM_AW-1:0];

  assign if_valid = (r_count != '0) && !rst;
  assign q_count  = rst ? '0 : r_count;
  assign if_pc    = r_q_pc[r_rd_ptr];
  assign if_pc4   = if_pc + STEP_C;
  assign if_inst  = r_q_inst[r_rd_ptr];

  inst_type_decoder u_dec (
    .i_inst (if_inst),
    .o_type (w_dec_type)
  );

  assign ID_ins_type   = if_valid ? w_dec_type : INST_TYPE_NONE;
  assign ID_ins_number = if_valid ? if_pc[3:0] : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc    <= RESET_PC;
      r_pend   <= 1'b0;
      r_rsp_pc <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_fpc    <= redirect_pc;
      r_pend   <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_issue) begin
        r_fpc    <= r_fpc + STEP_C;
        r_rsp_pc <= r_fpc;
      end
      r_pend <= w_issue;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage carries no reset; only entries counted by r_count are ever observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_dout;
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: cycle table on a DEPTH=4 instance, PC-stream
// scoreboard on accepted heads, and a free-running DEPTH=2 instance.
module tb_if_prefetch_stage;
  import if_prefetch_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        if_valid;
  logic [31:0] if_pc, if_pc4, if_inst;
  logic [3:0]  ID_ins_type, ID_ins_number;
  logic [2:0]  q_count;

  logic        rst2, stall2, redirect2;
  logic [31:0] redirect_pc2;
  logic        imem_rd2;
  logic [7:0]  imem_addr2;
  logic [31:0] imem_dout2;
  logic        if_valid2;
  logic [31:0] if_pc2, if_pc4_2, if_inst2;
  logic [3:0]  ID_ins_type2, ID_ins_number2;
  logic [1:0]  q_count2;

  if_prefetch_stage #(.ADDR_W(32), .IMEM_AW(8), .PC_STEP(1), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst),
    .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number), .q_count(q_count)
  );

  if_prefetch_stage #(.ADDR_W(32), .IMEM_AW(8), .PC_STEP(1), .DEPTH(2), .RESET_PC(32'h0)) u_dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .imem_rd(imem_rd2), .imem_addr(imem_addr2), .imem_dout(imem_dout2),
    .if_valid(if_valid2), .if_pc(if_pc2), .if_pc4(if_pc4_2), .if_inst(if_inst2),
    .ID_ins_type(ID_ins_type2), .ID_ins_number(ID_ins_number2), .q_count(q_count2)
  );

  logic [31:0] mem [256];
  always @(posedge clk) if (imem_rd)  imem_dout  <= mem[imem_addr];
  always @(posedge clk) if (imem_rd2) imem_dout2 <= mem[imem_addr2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, stall, redir;
    logic [31:0] rpc;
    int          e_valid, e_pc, e_cnt, e_rd, e_addr, e_type, e_num;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit s, bit d, logic [31:0] p,
                              int ev, int epc, int ecnt, int erd, int eaddr, int ety, int enm);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.rpc = p;
    v.e_valid = ev; v.e_pc = epc; v.e_cnt = ecnt; v.e_rd = erd;
    v.e_addr = eaddr; v.e_type = ety; v.e_num = enm;
    return v;
  endfunction

  // Scoreboard: expected PC stream, refilled whenever the bench drives a reset or redirect.
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(i));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (if_valid && !stall && !redirect && !rst) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          sb_e = exp_q.pop_front();
          $display("accept pc=0x%0h inst=0x%08h type=%0d", if_pc, if_inst, ID_ins_type);
          check("sb_pc", 64'(if_pc), 64'(sb_e));
          check("sb_pc4", 64'(if_pc4), 64'(sb_e + 32'd1));
          check("sb_inst", 64'(if_inst), 64'(mem[sb_e[7:0]]));
          check("sb_num", 64'(ID_ins_number), 64'(sb_e[3:0]));
        end
      end
    end
  end

  // DEPTH=2 instance: in-order stream, bubbles present but never two in a row.
  int          cyc2 = 0, bubbles2 = 0, accepts2 = 0;
  logic        prev_v2 = 1'b0;
  logic [31:0] exp2 = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst2) begin
        if (if_valid2) begin
          check("d2_pc", 64'(if_pc2), 64'(exp2));
          check("d2_inst", 64'(if_inst2), 64'(mem[exp2[7:0]]));
          exp2 = exp2 + 32'd1;
          accepts2++;
        end
        if (cyc2 >= 4 && !if_valid2) begin
          bubbles2++;
          check("d2_no_double_bubble", 64'(prev_v2), 64'd1);
        end
        prev_v2 = if_valid2;
        cyc2++;
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    mem[8'h21] = 32'h0043_0820;  // add $1,$2,$3
    mem[8'h22] = 32'h1022_0004;  // beq $1,$2,4
    mem[8'h30] = 32'hFC00_0000;  // opcode 0x3F
    sb_restart(32'h0);

    //            rst stl rdr rpc       vld  pc      cnt  rd  addr  type                     num
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  0,    int'(INST_TYPE_NONE),  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  0,      1,   1,  2,    -1,                    0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  1,      1,   1,  3,    -1,                    1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  2,     -1,  -1, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  3,     -1,  -1, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  4,     -1,  -1, -1,    -1,                   -1));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1,  5,      1,   1,  7,    -1,                    5));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1,  5,      2,   1,  8,    -1,                   -1));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1,  5,      3,   0, -1,    -1,                   -1));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1,  5,      4,   0, -1,    -1,                   -1));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1,  5,      4,   0, -1,    -1,                   -1));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1,  5,      4,   0, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  5,      4,   0, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  6,      3,   1,  9,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  7,      2,   1,  10,   -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  8,      2,   1,  11,   -1,                   -1));
    vecs.push_back(mk(0, 1, 0, 32'h0,    1,  9,      2,   1,  12,   -1,                   -1));
    vecs.push_back(mk(0, 0, 1, 32'h20,   1,  9,      3,   0, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  'h20, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  'h21, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  'h20,   1,  -1, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  'h21,   1,  -1, -1,    int'(INST_TYPE_ADD),   1));
    vecs.push_back(mk(0, 1, 1, 32'h30,   1,  'h22,  -1,   0, -1,    int'(INST_TYPE_BEQ),   2));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  'h30, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  'h31, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  'h30,   1,  -1, -1,    int'(INST_TYPE_NONE),  0));
    vecs.push_back(mk(1, 0, 1, 32'h40,   0,  -1,     0,   0, -1,    int'(INST_TYPE_NONE),  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  0,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  0,      1,  -1, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  1,     -1,  -1, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 1, 32'hFE,   1,  2,     -1,   0, -1,    -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  'hFE, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0,  -1,     0,   1,  'hFF, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  'hFE,   1,   1,  'h00, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  'hFF,  -1,   1,  'h01, -1,                   -1));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  'h100, -1,  -1, -1,    -1,                    0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1,  'h101, -1,  -1, -1,    -1,                    1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_rd", 64'(imem_rd), 64'd0);
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_count", 64'(q_count), 64'd0);
    check("rst_type", 64'(ID_ins_type), 64'(INST_TYPE_NONE));
    check("rst_num", 64'(ID_ins_number), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; stall = vecs[i].stall;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      rst2 = 1'b0;
      if (vecs[i].rst)        sb_restart(32'h0);
      else if (vecs[i].redir) sb_restart(vecs[i].rpc);
      @(negedge clk);
      if (vecs[i].e_valid >= 0) check($sformatf("c%0d_valid", i), 64'(if_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_pc    >= 0) check($sformatf("c%0d_pc", i), 64'(if_pc), 64'(vecs[i].e_pc));
      if (vecs[i].e_cnt   >= 0) check($sformatf("c%0d_count", i), 64'(q_count), 64'(vecs[i].e_cnt));
      if (vecs[i].e_rd    >= 0) check($sformatf("c%0d_imem_rd", i), 64'(imem_rd), 64'(vecs[i].e_rd));
      if (vecs[i].e_addr  >= 0) check($sformatf("c%0d_imem_addr", i), 64'(imem_addr), 64'(vecs[i].e_addr));
      if (vecs[i].e_type  >= 0) check($sformatf("c%0d_type", i), 64'(ID_ins_type), 64'(vecs[i].e_type));
      if (vecs[i].e_num   >= 0) check($sformatf("c%0d_num", i), 64'(ID_ins_number), 64'(vecs[i].e_num));
    end

    @(posedge clk);
    #1;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("d2_bubbles_seen", 64'(bubbles2 > 0), 64'd1);
    check("d2_accepts", 64'(accepts2 >= 10), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
